// File: rtl/alu_pkg.sv
// Shared op codes, mul/div state encoding and op decode helper for the
// alu_muldiv execute unit.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } md_state_t;

    function automatic logic op_is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 shift-add multiplier / restoring divider with sign fixup.
// done pulses on the final iteration with the corrected HI/LO values.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_t        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd, acc_hi, acc_lo, a_raw;
    logic             div_mode, neg_q, neg_r, div_zero;

    logic [WIDTH-1:0]   mag_a, mag_b, step_hi, step_lo;
    logic [WIDTH:0]     sum, shifted;
    logic               ge;
    logic [2*WIDTH-1:0] prod;

    assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

    // One iteration: multiply adds the multiplicand when the low bit is set and
    // shifts right; divide shifts the partial remainder left and subtracts.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        ge      = shifted >= {1'b0, opnd};
        if (div_mode) begin
            step_hi = ge ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ge};
        end else begin
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Divide by zero bypasses sign fixup so HI reports the original dividend.
    always_comb begin
        prod = {step_hi, step_lo};
        if (neg_q) prod = -prod;
        if (div_mode) begin
            if (div_zero) begin
                lo = '1;
                hi = a_raw;
            end else begin
                lo = neg_q ? -step_lo : step_lo;
                hi = neg_r ? -step_hi : step_hi;
            end
        end else begin
            hi = prod[2*WIDTH-1:WIDTH];
            lo = prod[WIDTH-1:0];
        end
    end

    assign busy = state != IDLE;
    assign done = (state == ITER) && (cnt == LAST) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            a_raw    <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ITER;
                        cnt      <= '0;
                        acc_hi   <= '0;
                        opnd     <= is_div ? mag_b : mag_a;
                        acc_lo   <= is_div ? mag_a : mag_b;
                        a_raw    <= a;
                        div_mode <= is_div;
                        neg_q    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= is_signed && a[WIDTH-1];
                        div_zero <= b == '0;
                    end
                end
                ITER: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// MIPS execute unit: registered single-cycle ALU plus an iterative mul/div
// engine writing HI/LO, with a valid/ready handshake for issue stalls.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             busy
);
    logic             fire, md_start, md_signed, md_div, md_done;
    logic [WIDTH-1:0] hi, lo, md_hi, md_lo;
    logic [WIDTH-1:0] sum, diff, alu_result;
    logic             alu_overflow, alu_illegal;

    assign in_ready  = !busy;
    assign fire      = in_valid && in_ready;
    assign md_start  = fire && op_is_muldiv(op);
    assign md_signed = (op == OP_MULT) || (op == OP_DIV);
    assign md_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign sum       = a + b;
    assign diff      = a - b;

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .flush     (flush),
        .is_div    (md_div),
        .is_signed (md_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        alu_illegal  = 1'b0;
        case (op)
            OP_AND:  alu_result = a & b;
            OP_OR:   alu_result = a | b;
            OP_XOR:  alu_result = a ^ b;
            OP_NOR:  alu_result = ~(a | b);
            OP_ADD: begin
                alu_result   = sum;
                alu_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result   = diff;
                alu_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  alu_result = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: alu_result = WIDTH'(a < b);
            OP_MFHI: alu_result = hi;
            OP_MFLO: alu_result = lo;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: alu_result = '0;
            default: alu_illegal = 1'b1;
        endcase
    end

    // Flags are only meaningful alongside out_valid, so they drop with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            out_valid <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            if (md_done) begin
                out_valid <= 1'b1;
                result    <= md_lo;
                zero      <= md_lo == '0;
                hi        <= md_hi;
                lo        <= md_lo;
            end else if (fire && !op_is_muldiv(op)) begin
                out_valid <= 1'b1;
                result    <= alu_result;
                zero      <= alu_result == '0;
                overflow  <= alu_overflow;
                illegal   <= alu_illegal;
            end
        end
    end

endmodule
